// File: rtl/edac_scrub_ctrl_if.sv
// EDAC scrub controller bus bundle: CPU read port, memory/LUT port
// and decoder port. master = controller side, slave = environment side.
interface edac_scrub_ctrl_if #(
  parameter int ADDR_W = 6
);
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ack;
  logic [7:0]        cpu_data;
  logic              cpu_err;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_rdata;
  logic [31:0]       lut_rdata;
  logic              lut_we;
  logic [31:0]       lut_wdata;
  logic              dec_en;
  logic              dec_read;
  logic [31:0]       dec_din;
  logic [31:0]       dec_lut_in;
  logic [31:0]       dec_dout;
  logic [31:0]       dec_lut_out;
  logic              dec_valid;

  modport master (
    input  cpu_req, cpu_addr, mem_rdata, lut_rdata,
    input  dec_dout, dec_lut_out, dec_valid,
    output cpu_ack, cpu_data, cpu_err, mem_rd, mem_addr,
    output lut_we, lut_wdata, dec_en, dec_read,
    output dec_din, dec_lut_in
  );

  modport slave (
    output cpu_req, cpu_addr, mem_rdata, lut_rdata,
    output dec_dout, dec_lut_out, dec_valid,
    input  cpu_ack, cpu_data, cpu_err, mem_rd, mem_addr,
    input  lut_we, lut_wdata, dec_en, dec_read,
    input  dec_din, dec_lut_in
  );
endinterface

// File: rtl/edac_scrub_ctrl.sv
// EDAC read/scrub controller with LUT write-back.
// Define EDAC_SCRUB_STAT_EN to build the error/correction counters.
module edac_scrub_ctrl #(
  parameter int          ADDR_W    = 6,
  parameter logic [15:0] SCRUB_GAP = 16'd1000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  scrub_en,
  edac_scrub_ctrl_if.master     bus,
  output logic                  busy,
  output logic [15:0]           err_cnt,
  output logic [15:0]           corr_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_RD, S_DEC, S_WB, S_RESP
  } state_e;

  state_e            state_q;
  logic              src_cpu_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] ptr_q;
  logic [15:0]       gap_q;
  logic [7:0]        data_q;
  logic              uncorr_q;

  logic              mem_rd_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic              lut_we_q;
  logic [31:0]       wdata_q;
  logic              dec_en_q;
  logic              ack_q;
  logic [7:0]        cpu_data_q;
  logic              cpu_err_q;
  logic              busy_q;

  logic              uncorr_now;
  logic              need_wb;

  assign uncorr_now = (bus.dec_dout == 32'hFFFF_FFFF);
  assign need_wb    = bus.dec_valid &&
                      (bus.dec_lut_out != bus.lut_rdata);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= S_IDLE;
      src_cpu_q  <= 1'b0;
      addr_q     <= '0;
      ptr_q      <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      uncorr_q   <= 1'b0;
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      lut_we_q   <= 1'b0;
      wdata_q    <= '0;
      dec_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      cpu_data_q <= '0;
      cpu_err_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      mem_rd_q   <= 1'b0;
      mem_addr_q <= '0;
      lut_we_q   <= 1'b0;
      wdata_q    <= '0;
      dec_en_q   <= 1'b0;
      ack_q      <= 1'b0;
      cpu_data_q <= '0;
      cpu_err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cpu_req) begin
            state_q    <= S_RD;
            src_cpu_q  <= 1'b1;
            addr_q     <= bus.cpu_addr;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
            busy_q     <= 1'b1;
          end else if (scrub_en) begin
            state_q <= S_GAP;
            gap_q   <= SCRUB_GAP - 16'd1;
          end
        end
        S_GAP: begin
          // CPU preemption leaves the gap count untouched
          if (bus.cpu_req) begin
            state_q    <= S_RD;
            src_cpu_q  <= 1'b1;
            addr_q     <= bus.cpu_addr;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= bus.cpu_addr;
            busy_q     <= 1'b1;
          end else if (!scrub_en) begin
            state_q <= S_IDLE;
          end else if (gap_q == 16'd0) begin
            state_q    <= S_RD;
            src_cpu_q  <= 1'b0;
            addr_q     <= ptr_q;
            mem_rd_q   <= 1'b1;
            mem_addr_q <= ptr_q;
            busy_q     <= 1'b1;
          end else begin
            gap_q <= gap_q - 16'd1;
          end
        end
        S_RD: begin
          state_q  <= S_DEC;
          dec_en_q <= 1'b1;
        end
        S_DEC: begin
          data_q   <= bus.dec_dout[7:0];
          uncorr_q <= uncorr_now;
          if (need_wb) begin
            state_q    <= S_WB;
            lut_we_q   <= 1'b1;
            mem_addr_q <= addr_q;
            wdata_q    <= bus.dec_lut_out;
          end else begin
            state_q    <= S_RESP;
            ack_q      <= src_cpu_q;
            cpu_data_q <= src_cpu_q ? bus.dec_dout[7:0] : 8'h00;
            cpu_err_q  <= src_cpu_q & uncorr_now;
          end
        end
        S_WB: begin
          state_q    <= S_RESP;
          ack_q      <= src_cpu_q;
          cpu_data_q <= src_cpu_q ? data_q : 8'h00;
          cpu_err_q  <= src_cpu_q & uncorr_q;
        end
        S_RESP: begin
          busy_q <= 1'b0;
          if (src_cpu_q) begin
            if (gap_q != 16'd0 && scrub_en) state_q <= S_GAP;
            else                            state_q <= S_IDLE;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
            if (scrub_en) begin
              state_q <= S_GAP;
              gap_q   <= SCRUB_GAP - 16'd1;
            end else begin
              state_q <= S_IDLE;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_rd     = mem_rd_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.lut_we     = lut_we_q;
  assign bus.lut_wdata  = wdata_q;
  assign bus.dec_en     = dec_en_q;
  assign bus.dec_read   = dec_en_q;
  assign bus.dec_din    = dec_en_q ? bus.mem_rdata : 32'h0;
  assign bus.dec_lut_in = dec_en_q ? bus.lut_rdata : 32'h0;
  assign bus.cpu_ack    = ack_q;
  assign bus.cpu_data   = cpu_data_q;
  assign bus.cpu_err    = cpu_err_q;
  assign busy           = busy_q;

`ifdef EDAC_SCRUB_STAT_EN
  logic [15:0] err_q;
  logic [15:0] corr_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      err_q  <= '0;
      corr_q <= '0;
    end else begin
      if (state_q == S_WB && corr_q != 16'hFFFF)
        corr_q <= corr_q + 16'd1;
      if (state_q == S_RESP && uncorr_q && err_q != 16'hFFFF)
        err_q <= err_q + 16'd1;
    end
  end

  assign err_cnt  = err_q;
  assign corr_cnt = corr_q;
`else
  assign err_cnt  = 16'h0;
  assign corr_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_edac_scrub_ctrl.sv
// Bench for edac_scrub_ctrl: vector table, random CPU reads against a
// transaction model, and scrub/reset sequences on two instances.
module tb_edac_scrub_ctrl;

`ifdef EDAC_SCRUB_STAT_EN
  localparam int STAT = 1;
`else
  localparam int STAT = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic scrub_a, scrub_b;
  logic busy_a, busy_b;
  logic [15:0] err_a, corr_a, err_b, corr_b;

  edac_scrub_ctrl_if #(.ADDR_W(6)) ia ();
  edac_scrub_ctrl_if #(.ADDR_W(2)) ib ();

  edac_scrub_ctrl #(.ADDR_W(6), .SCRUB_GAP(16'd4)) dut_a (
    .CLK(clk), .RST(rst), .scrub_en(scrub_a), .bus(ia.master),
    .busy(busy_a), .err_cnt(err_a), .corr_cnt(corr_a)
  );

  edac_scrub_ctrl #(.ADDR_W(2), .SCRUB_GAP(16'd4)) dut_b (
    .CLK(clk), .RST(rst), .scrub_en(scrub_b), .bus(ib.master),
    .busy(busy_b), .err_cnt(err_b), .corr_cnt(corr_b)
  );

  always #5 clk = ~clk;

  // decoder stand-in for instance A: response chosen per transaction
  logic [31:0] dout_v, flip_v;
  logic        valid_v;
  assign ia.dec_dout    = dout_v;
  assign ia.dec_valid   = valid_v;
  assign ia.dec_lut_out = ia.lut_rdata ^ flip_v;

  // instance B sees clean, matching memory and LUT words
  assign ib.mem_rdata   = 32'h5A5A_5A5A;
  assign ib.lut_rdata   = 32'h5A5A_5A5A;
  assign ib.dec_dout    = 32'h0000_0011;
  assign ib.dec_valid   = 1'b1;
  assign ib.dec_lut_out = ib.lut_rdata;

  logic [31:0] memA [64];
  logic [31:0] lutA [64];

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        memA[i] <= {26'h0, 6'(i)} ^ 32'hC3A5_9600;
        lutA[i] <= {26'h0, 6'(i)} ^ 32'hC3A5_9600;
      end
      ia.mem_rdata <= '0;
      ia.lut_rdata <= '0;
    end else begin
      if (ia.mem_rd) begin
        ia.mem_rdata <= memA[ia.mem_addr];
        ia.lut_rdata <= lutA[ia.mem_addr];
      end
      if (ia.lut_we) begin
        memA[ia.mem_addr] <= ia.lut_wdata;
        lutA[ia.mem_addr] <= ia.lut_wdata;
      end
    end
  end

  int n_pass = 0;
  int n_total = 0;
  int mcorr = 0;
  int merr = 0;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, got, exp);
  endtask

  typedef struct {
    logic [5:0]  a;
    logic [31:0] dout;
    logic        vld;
    logic [31:0] flip;
    logic [7:0]  d;
    logic        e;
    logic        wb;
  } vec_t;

  // caller is #1 after an edge with instance A idle
  task automatic cpu_read(input vec_t v, output int lat,
                          output logic [7:0] d, output logic e,
                          output int nwe, output logic [5:0] wa,
                          output logic [31:0] wd);
    dout_v = v.dout;
    valid_v = v.vld;
    flip_v = v.flip;
    ia.cpu_addr = v.a;
    ia.cpu_req = 1'b1;
    lat = 99; nwe = 0; wa = '0; wd = '0; d = '0; e = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (ia.lut_we) begin
        nwe++;
        wa = ia.mem_addr;
        wd = ia.lut_wdata;
      end
      if (ia.cpu_ack) begin
        lat = c;
        d = ia.cpu_data;
        e = ia.cpu_err;
        break;
      end
    end
    ia.cpu_req = 1'b0;
  endtask

  task automatic xact(input string tag, input vec_t v);
    int lat, nwe;
    logic [7:0] d;
    logic e;
    logic [5:0] wa;
    logic [31:0] wd, exp_wd;
    exp_wd = lutA[v.a] ^ v.flip;
    cpu_read(v, lat, d, e, nwe, wa, wd);
    chk({tag, "_lat"}, lat, v.wb ? 4 : 3);
    chk({tag, "_data"}, {24'h0, d}, {24'h0, v.d});
    chk({tag, "_err"}, {31'h0, e}, {31'h0, v.e});
    chk({tag, "_nwe"}, nwe, v.wb ? 1 : 0);
    if (v.wb) begin
      chk({tag, "_waddr"}, {26'h0, wa}, {26'h0, v.a});
      chk({tag, "_wdata"}, wd, exp_wd);
    end
    if (v.wb) mcorr++;
    if (v.e) merr++;
    @(posedge clk); #1;
    chk({tag, "_ack_once"}, {31'h0, ia.cpu_ack}, 0);
    chk({tag, "_data_hold"}, {24'h0, ia.cpu_data}, 0);
    chk({tag, "_corr"}, {16'h0, corr_a}, STAT ? mcorr : 0);
    chk({tag, "_errc"}, {16'h0, err_a}, STAT ? merr : 0);
  endtask

  vec_t tbl[6];
  int times[$];
  logic [5:0] addrs[$];
  int nwe_s;
  vec_t rv;

  initial begin
    tbl[0] = '{6'd5,  32'h0000_00A5, 1'b1, 32'h0,         8'hA5, 1'b0, 1'b0};
    tbl[1] = '{6'd9,  32'h0000_003C, 1'b1, 32'h0000_0010, 8'h3C, 1'b0, 1'b1};
    tbl[2] = '{6'd12, 32'hFFFF_FFFF, 1'b0, 32'h0,         8'hFF, 1'b1, 1'b0};
    tbl[3] = '{6'd63, 32'h1234_5600, 1'b0, 32'h0000_0001, 8'h00, 1'b0, 1'b0};
    tbl[4] = '{6'd0,  32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 8'hFF, 1'b1, 1'b1};
    tbl[5] = '{6'd33, 32'h0000_007E, 1'b1, 32'h0,         8'h7E, 1'b0, 1'b0};

    rst = 1'b1;
    scrub_a = 1'b0; scrub_b = 1'b0;
    ia.cpu_req = 1'b0; ia.cpu_addr = '0;
    ib.cpu_req = 1'b0; ib.cpu_addr = '0;
    dout_v = '0; valid_v = 1'b1; flip_v = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_rd", {31'h0, ia.mem_rd}, 0);
    chk("rst_lut_we", {31'h0, ia.lut_we}, 0);
    chk("rst_ack", {31'h0, ia.cpu_ack}, 0);
    chk("rst_dec_en", {31'h0, ia.dec_en}, 0);
    chk("rst_dec_din", ia.dec_din, 0);
    chk("rst_busy", {31'h0, busy_a}, 0);
    chk("rst_cnts", {err_a, corr_a}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // clean background scrub on A: period 4 gap + 3 access cycles
    dout_v = 32'h0000_0042; valid_v = 1'b1; flip_v = '0;
    scrub_a = 1'b1;
    nwe_s = 0;
    for (int c = 0; c < 60 && times.size() < 4; c++) begin
      @(posedge clk); #1;
      if (ia.lut_we) nwe_s++;
      if (ia.mem_rd) begin
        times.push_back(c);
        addrs.push_back(ia.mem_addr);
      end
    end
    chk("scrub_a_count", times.size(), 4);
    for (int i = 1; i < times.size(); i++)
      chk($sformatf("scrub_a_period%0d", i), times[i] - times[i-1], 7);
    for (int i = 0; i < addrs.size(); i++)
      chk($sformatf("scrub_a_addr%0d", i), {26'h0, addrs[i]}, i);
    scrub_a = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("scrub_a_no_we", nwe_s, 0);
    chk("scrub_a_idle", {31'h0, busy_a}, 0);

    // narrow-address scrub on B: pointer wraps after 3
    times.delete();
    addrs.delete();
    scrub_b = 1'b1;
    for (int c = 0; c < 80 && addrs.size() < 5; c++) begin
      @(posedge clk); #1;
      if (ib.mem_rd) addrs.push_back({4'h0, ib.mem_addr});
    end
    scrub_b = 1'b0;
    chk("scrub_b_count", addrs.size(), 5);
    for (int i = 0; i < addrs.size(); i++)
      chk($sformatf("scrub_b_addr%0d", i), {26'h0, addrs[i]}, i % 4);
    repeat (10) @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      xact($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 20; i++) begin
      rv.a = 6'($urandom_range(0, 63));
      rv.vld = 1'($urandom % 2);
      rv.flip = ($urandom % 2 == 1) ? (32'h1 << ($urandom % 32)) : 32'h0;
      rv.dout = ($urandom % 4 == 0) ? 32'hFFFF_FFFF : $urandom;
      rv.d = rv.dout[7:0];
      rv.e = (rv.dout == 32'hFFFF_FFFF);
      rv.wb = rv.vld && (rv.flip != 32'h0);
      xact($sformatf("rnd%0d", i), rv);
    end

    // reset while the write-back is on the bus
    dout_v = 32'h0000_0055; valid_v = 1'b1; flip_v = 32'h0000_0100;
    ia.cpu_addr = 6'd7;
    ia.cpu_req = 1'b1;
    nwe_s = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (ia.lut_we) begin
        nwe_s = 1;
        break;
      end
    end
    chk("wbrst_we_seen", nwe_s, 1);
    chk("wbrst_corr_pre", {16'h0, corr_a}, STAT ? mcorr : 0);
    rst = 1'b1;
    ia.cpu_req = 1'b0;
    @(posedge clk); #1;
    chk("wbrst_we", {31'h0, ia.lut_we}, 0);
    chk("wbrst_busy", {31'h0, busy_a}, 0);
    chk("wbrst_ack", {31'h0, ia.cpu_ack}, 0);
    chk("wbrst_cnts", {err_a, corr_a}, 0);
    rst = 1'b0;
    mcorr = 0;
    merr = 0;
    @(posedge clk); #1;
    xact("post_rst", tbl[0]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
